// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity modes
// and the parity-bit helper used by both directions.
package uart_pkg;

    localparam int unsigned MAX_DATA_BITS = 9;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_CLEANUP,
        ST_WAIT_IDLE
    } uart_state_e;

    // Parity bit that a correct frame carries; unused upper data bits must be 0.
    function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                        input int unsigned              mode);
        return (mode == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Received-word bus from the UART receiver to the register/FIFO front end.
interface uart_rx_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 o_Rx_DV;
    logic [DATA_BITS-1:0] o_Rx_Byte;
    logic                 o_Frame_Err;
    logic                 o_Parity_Err;
    logic                 o_Break;
    logic                 o_Busy;

    modport master (
        output o_Rx_DV, o_Rx_Byte, o_Frame_Err, o_Parity_Err, o_Break, o_Busy
    );

    modport slave (
        input o_Rx_DV, o_Rx_Byte, o_Frame_Err, o_Parity_Err, o_Break, o_Busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input that idles high.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver reporting framing, parity and break status per word.
// Define UART_RX_PARITY_EN to enable the parity bit selected by PARITY_MODE.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_MODE  = PARITY_NONE
) (
    input  logic            i_Clock,
    input  logic            i_Reset,
    input  logic            i_Rx_Serial,
    uart_rx_param_if.master rx
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
    localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("uart_rx_param: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
        $error("uart_rx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (PARITY_MODE > PARITY_EVEN) begin : g_bad_parity
        $error("uart_rx_param: PARITY_MODE must be 0..2");
    end

    uart_state_e          state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 frm_q, frm_n;
    logic                 par_q, par_n;
    logic                 pbit_q, pbit_n;
    logic                 dv_q, dv_n;
    logic [DATA_BITS-1:0] byte_q, byte_n;
    logic                 ferr_q, ferr_n;
    logic                 perr_q, perr_n;
    logic                 brk_q, brk_n;
    logic                 busy_q, busy_n;
    logic                 rx_sync;
    logic                 bit_tick;

    uart_sync2 u_sync (
        .clk (i_Clock),
        .rst (i_Reset),
        .d   (i_Rx_Serial),
        .q   (rx_sync)
    );

    // Next-state and next-output logic; status outputs pulse only on the final stop sample.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        data_n   = data_q;
        frm_n    = frm_q;
        par_n    = par_q;
        pbit_n   = pbit_q;
        dv_n     = 1'b0;
        byte_n   = byte_q;
        ferr_n   = 1'b0;
        perr_n   = 1'b0;
        brk_n    = 1'b0;
        bit_tick = (cnt == CNT_W'(CLKS_PER_BIT - 1));

        unique case (state)
            ST_IDLE: begin
                cnt_n  = '0;
                idx_n  = '0;
                frm_n  = 1'b0;
                par_n  = 1'b0;
                pbit_n = 1'b0;
                if (!rx_sync) state_n = ST_START;
            end
            ST_START: begin
                if (cnt == CNT_W'(HALF)) begin
                    cnt_n   = '0;
                    state_n = rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    cnt_n = '0;
                    for (int i = 0; i < int'(DATA_BITS); i++) begin
                        if (idx == IDX_W'(i)) data_n[i] = rx_sync;
                    end
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_n = '0;
`ifdef UART_RX_PARITY_EN
                        state_n = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
`else
                        state_n = ST_STOP;
`endif
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    cnt_n   = '0;
                    pbit_n  = rx_sync;
                    par_n   = (rx_sync != parity_bit(MAX_DATA_BITS'(data_q), PARITY_MODE));
                    state_n = ST_STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    cnt_n = '0;
                    if (!rx_sync) frm_n = 1'b1;
                    if (idx == IDX_W'(STOP_BITS - 1)) begin
                        idx_n   = '0;
                        state_n = ST_CLEANUP;
                        dv_n    = 1'b1;
                        byte_n  = data_q;
                        ferr_n  = frm_n;
                        perr_n  = par_q;
                        brk_n   = frm_n && (data_q == '0) && !pbit_q;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_CLEANUP: begin
                state_n = frm_q ? ST_WAIT_IDLE : ST_IDLE;
            end
            ST_WAIT_IDLE: begin
                if (rx_sync) state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n = (state_n != ST_IDLE);
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            idx    <= '0;
            data_q <= '0;
            frm_q  <= 1'b0;
            par_q  <= 1'b0;
            pbit_q <= 1'b0;
            dv_q   <= 1'b0;
            byte_q <= '0;
            ferr_q <= 1'b0;
            perr_q <= 1'b0;
            brk_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            data_q <= data_n;
            frm_q  <= frm_n;
            par_q  <= par_n;
            pbit_q <= pbit_n;
            dv_q   <= dv_n;
            byte_q <= byte_n;
            ferr_q <= ferr_n;
            perr_q <= perr_n;
            brk_q  <= brk_n;
            busy_q <= busy_n;
        end
    end

    assign rx.o_Rx_DV      = dv_q;
    assign rx.o_Rx_Byte    = byte_q;
    assign rx.o_Frame_Err  = ferr_q;
    assign rx.o_Parity_Err = perr_q;
    assign rx.o_Break      = brk_q;
    assign rx.o_Busy       = busy_q;
endmodule
